// File: rtl/bus_sync_tx.sv
// rtl/bus_sync_tx.sv - registered multi-bit bus launcher with enforced post-change hold time
// Optional one-entry pending buffer enabled by defining BUS_SYNC_TX_PEND_EN.
module bus_sync_tx #(
    parameter int Bus_BW   = 8,
    parameter int HOLD_CYC = 6,
    parameter int CNT_W    = 4
) (
    input  logic              src_clk,
    input  logic              src_rstn,
    input  logic [Bus_BW-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [Bus_BW-1:0] Bus_out,
    output logic              tx_strobe,
    output logic              busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [Bus_BW-1:0] bus_q, bus_d;
    logic              strobe_q, strobe_d;
    logic              xfer;
    logic              launch_en;
    logic [Bus_BW-1:0] launch_word;

`ifdef BUS_SYNC_TX_PEND_EN
    logic              pend_vld_q, pend_vld_d;
    logic [Bus_BW-1:0] pend_data_q, pend_data_d;

    assign in_ready = ~pend_vld_q;
    assign busy     = (state_q == HOLD) | pend_vld_q;
`else
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == HOLD);
`endif

    assign xfer      = in_valid & in_ready;
    assign Bus_out   = bus_q;
    assign tx_strobe = strobe_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        strobe_d    = 1'b0;
        launch_en   = 1'b0;
        launch_word = in_data;
`ifdef BUS_SYNC_TX_PEND_EN
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BUS_SYNC_TX_PEND_EN
                // A buffered word has priority; in_ready is low while it waits.
                if (pend_vld_q) begin
                    pend_vld_d  = 1'b0;
                    launch_en   = (pend_data_q != bus_q);
                    launch_word = pend_data_q;
                end else begin
                    launch_en   = xfer && (in_data != bus_q);
                end
`else
                launch_en = xfer && (in_data != bus_q);
`endif
            end
            HOLD: begin
`ifdef BUS_SYNC_TX_PEND_EN
                if (xfer) begin
                    pend_vld_d  = 1'b1;
                    pend_data_d = in_data;
                end
`endif
                if (cnt_q == '0) begin
                    // A differing pending word launches from IDLE one edge later,
                    // which keeps launch spacing at HOLD_CYC+1 cycles.
                    state_d = IDLE;
`ifdef BUS_SYNC_TX_PEND_EN
                    if (pend_vld_q && (pend_data_q == bus_q)) begin
                        pend_vld_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch_en) begin
            bus_d    = launch_word;
            cnt_d    = CNT_LOAD;
            strobe_d = 1'b1;
            state_d  = HOLD;
        end
    end

    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bus_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            strobe_q <= strobe_d;
        end
    end

`ifdef BUS_SYNC_TX_PEND_EN
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
        end
    end
`endif

endmodule
